// File: rtl/muxn_pipe.sv
// -----------------------------------------------------------------------------
// muxn_pipe
//   Parametrised N-to-1 data-path selector with a registered output stage,
//   a one-entry skid buffer and valid/ready flow control on both sides.
//   A beat with an out-of-range select is passed on as zero data with
//   out_sel_err set, so the consumer sees the fault in order with the data.
//
// Parameters
//   WIDTH   data width of each source and of the output
//   NUM_IN  number of sources, legal range 2..16
//   SEL_W   select width, derived from NUM_IN (do not override)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   flush        synchronous flush; empties the main register and the skid entry
//   select       source index, sampled when an input beat is accepted
//   in_bus       packed sources; source k = in_bus[k*WIDTH +: WIDTH]
//   in_valid     input beat valid
//   in_ready     block can accept a beat (driven from a register only)
//   out_data     selected, registered data
//   out_sel_err  beat was produced from an out-of-range select
//   out_valid    output beat valid
//   out_ready    consumer accepts the output beat
//   err_count    saturating count of accepted out-of-range selects
//
// Configuration
//   MUXN_ERR_CNT_EN  when defined, err_count counts accepted beats with an
//                    out-of-range select (saturating at 8'hFF, cleared by
//                    reset only). When undefined, err_count is tied to 8'h00.
// -----------------------------------------------------------------------------
module muxn_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        select,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              err_count
);

  // Selected beat for the current cycle
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  // Skid entry
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             skid_valid;

  logic accept;
  logic consume;
  logic main_free;

  // in_ready comes straight from the skid flag, so there is no
  // in_valid -> in_ready combinational path.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  // Main register can take a new value this edge if it is empty or draining.
  assign main_free = !out_valid || out_ready;

  // Source selection. Any index with no matching source leaves the defaults
  // in place: zero data with the error flag raised.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (select == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

  // Main output register and skid entry.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data    <= '0;
      out_sel_err <= 1'b0;
      out_valid   <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (flush) begin
      // Flush wins over everything: any beat offered this cycle is dropped,
      // while a consumer handshake this cycle has already taken its beat.
      out_data    <= '0;
      out_sel_err <= 1'b0;
      out_valid   <= 1'b0;
      skid_err    <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        // Older beat waiting in the skid goes first. in_ready is low
        // whenever the skid is full, so no new beat can collide here.
        out_data    <= skid_data;
        out_sel_err <= skid_err;
        out_valid   <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_data    <= sel_data;
        out_sel_err <= sel_err;
        out_valid   <= 1'b1;
      end else begin
        // Drained with nothing behind it: data and flag keep their last value.
        out_valid   <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled; park the beat in the skid and stop accepting.
      skid_data  <= sel_data;
      skid_err   <= sel_err;
      skid_valid <= 1'b1;
    end
  end

`ifdef MUXN_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // A beat offered during flush is discarded, so it is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else if (accept && !flush && sel_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'h00;
`endif

  // consume is kept for readability of the handshake; main_free covers it.
  logic unused_consume;
  assign unused_consume = consume;

endmodule
